// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the demux pulse sequencer.
// State encoding for the sequencer FSM plus the effective-length rule.
package demux_seq_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      GUARD = 2'd3
   } state_t;

   // A programmed length of 0 still produces a single-cycle pulse.
   function automatic int unsigned eff_len(input int unsigned len);
      return (len == 0) ? 32'd1 : len;
   endfunction

endpackage

// File: rtl/demux_pulse_seq_pulse_timer.sv
// pulse_timer: loadable down-counter that measures the PULSE phase.
// Load wins over decrement; the counter parks at zero and flags it.
module pulse_timer #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [LEN_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [LEN_W-1:0] cnt_q;
   logic [LEN_W-1:0] cnt_d;

   // Next count: reload on a new request, otherwise count down to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - LEN_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/demux_pulse_seq.sv
// demux_pulse_seq: drives sel/data of a 1-to-N demux so that sel is
// settled one cycle before data rises and held one guard cycle after it
// falls. Requests arrive on a valid/ready handshake.
// Optional build macro DEMUX_SCAN_AUTO_EN adds scan_en and a round-robin
// scan pointer that self-issues requests while no explicit one is pending.
module demux_pulse_seq
   import demux_seq_pkg::*;
#(
   parameter int N        = 8,
   parameter int SEL_W    = 3,
   parameter int LEN_W    = 4,
   parameter int SCAN_LEN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [SEL_W-1:0] req_ch,
   input  logic [LEN_W-1:0] req_len,
   output logic [SEL_W-1:0] sel,
   output logic             data,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef DEMUX_SCAN_AUTO_EN
   ,
   input  logic             scan_en
`endif
);

   // Channel limit widened by one bit so N itself is representable.
   localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

   // Elaboration-time sanity checks on the configuration.
   if ((2 ** SEL_W) < N) begin : g_bad_sel_w
      $error("SEL_W too narrow for N channels");
   end
   if ((SCAN_LEN >> LEN_W) != 0) begin : g_bad_scan_len
      $error("SCAN_LEN does not fit in LEN_W bits");
   end

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             data_q, data_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             issue_valid;
   logic [SEL_W-1:0] issue_ch;
   logic [LEN_W-1:0] issue_len;
   logic             ch_ok;
   logic             accept;

   logic             timer_load;
   logic [LEN_W-1:0] timer_val;
   logic             timer_zero;

`ifdef DEMUX_SCAN_AUTO_EN
   localparam logic [LEN_W-1:0] SCAN_L = LEN_W'(eff_len(SCAN_LEN));

   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             scan_q, scan_d;
   logic             issue_scan;

   // Request source: an explicit request always beats the scan pointer.
   always_comb begin
      issue_valid = req_valid;
      issue_ch    = req_ch;
      issue_len   = LEN_W'(eff_len(32'(req_len)));
      issue_scan  = 1'b0;
      if (!req_valid && scan_en) begin
         issue_valid = 1'b1;
         issue_ch    = ptr_q;
         issue_len   = SCAN_L;
         issue_scan  = 1'b1;
      end
   end

   // Remember whether the transaction in flight came from the scanner and
   // advance the pointer on the edge that raises that transaction's done.
   always_comb begin
      scan_d = scan_q;
      ptr_d  = ptr_q;
      if (accept) begin
         scan_d = issue_scan;
      end
      if ((state_q == GUARD) && scan_q) begin
         ptr_d = (ptr_q == SEL_W'(N - 1)) ? '0 : ptr_q + SEL_W'(1);
      end
   end

   // Scan pointer and origin flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q  <= '0;
         scan_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         scan_q <= scan_d;
      end
   end
`else
   assign issue_valid = req_valid;
   assign issue_ch    = req_ch;
   assign issue_len   = LEN_W'(eff_len(32'(req_len)));
`endif

   assign ch_ok  = ({1'b0, issue_ch} < N_L);
   assign accept = (state_q == IDLE) && issue_valid && ch_ok;

   pulse_timer #(
      .LEN_W (LEN_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .en_i       (state_q == PULSE),
      .zero_o     (timer_zero)
   );

   // Next-state and registered-output decode for the sequencer.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      data_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      timer_load = 1'b0;
      timer_val  = issue_len - LEN_W'(1);
      case (state_q)
         IDLE: begin
            if (issue_valid) begin
               if (ch_ok) begin
                  sel_d      = issue_ch;
                  timer_load = 1'b1;
                  state_d    = SETUP;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SETUP: begin
            state_d = PULSE;
            data_d  = 1'b1;
         end
         PULSE: begin
            if (timer_zero) begin
               state_d = GUARD;
            end else begin
               data_d = 1'b1;
            end
         end
         GUARD: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops data and cancels done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         data_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign sel       = sel_q;
   assign data      = data_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = (state_q != IDLE);
   assign req_ready = (state_q == IDLE);

endmodule
